// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder that handles BITS_PER_CYCLE bits per clock, LSB slice first.
// Each slice goes through a ripple of full-adder cells, and the carry between slices is registered.
// Start/done handshake. The result holds until the next operation completes.
// Optional feature: define SERIAL_ADDER_SUB_EN to add a sub_i port (a - b - cin).
module serial_adder #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub_i,
`endif
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int unsigned NBeats = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned BeatW  = (NBeats > 1) ? $clog2(NBeats) : 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(NBeats - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [WIDTH-1:0]    a_q, a_d;
  logic [WIDTH-1:0]    b_q, b_d;     // holds b_eff (already inverted for subtract)
  logic                carry_q, carry_d;
  logic [BeatW-1:0]    beat_q, beat_d;
  logic [WIDTH-1:0]    partial_q, partial_d;
  logic [WIDTH-1:0]    sum_q, sum_d;
  logic                cout_q, cout_d;
  logic                ovf_q, ovf_d;

  logic                      sub_w;
  logic [31:0]               slice_lsb;
  logic [BITS_PER_CYCLE-1:0] a_sl, b_sl, s_sl;
  logic                      c_sl;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_w = sub_i;
`else
  assign sub_w = 1'b0;
`endif

  assign slice_lsb = 32'(beat_q) * BITS_PER_CYCLE;

  // Ripple one slice of the latched operands through full-adder cells
  always_comb begin
    logic c;
    a_sl = a_q[slice_lsb +: BITS_PER_CYCLE];
    b_sl = b_q[slice_lsb +: BITS_PER_CYCLE];
    s_sl = '0;
    c    = carry_q;
    for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
      s_sl[i] = a_sl[i] ^ b_sl[i] ^ c;
      c       = (a_sl[i] & b_sl[i]) | (c & (a_sl[i] ^ b_sl[i]));
    end
    c_sl = c;
  end

  // FSM next state, operand capture, slice accumulation and result load
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    carry_d   = carry_q;
    beat_d    = beat_q;
    partial_d = partial_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d   = StBusy;
          a_d       = a_i;
          b_d       = b_i ^ {WIDTH{sub_w}};
          carry_d   = cin_i ^ sub_w;
          beat_d    = '0;
          partial_d = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StBusy: begin
        partial_d[slice_lsb +: BITS_PER_CYCLE] = s_sl;
        carry_d = c_sl;
        beat_d  = beat_q + BeatW'(1);
        if (beat_q == LastBeat) begin
          state_d = StDone;
          sum_d   = partial_d;
          cout_d  = c_sl;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (partial_d[WIDTH-1] != a_q[WIDTH-1]);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset aborts any operation in flight
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      beat_q    <= '0;
      partial_q <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      carry_q   <= carry_d;
      beat_q    <= beat_d;
      partial_q <= partial_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      ovf_q     <= ovf_d;
    end
  end

  assign busy_o = (state_q == StBusy);
  assign done_o = (state_q == StDone);
  assign sum_o  = sum_q;
  assign cout_o = cout_q;
  assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: an 8-bit/1-bit-per-clock instance and a 16-bit/4-bit
// instance. Stimulus pushes expected {sum, cout, ovf}; monitors pop on each done pulse.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        start8 = 1'b0, cin8 = 1'b0, sub8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, cout8, ovf8;
  logic [7:0]  sum8;

  logic        start16 = 1'b0, cin16 = 1'b0, sub16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, cout16, ovf16;
  logic [15:0] sum16;

  int errors = 0;
  int checks = 0;

  logic [9:0]  q8[$];
  logic [17:0] q16[$];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut8 (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start8),
    .a_i     (a8),
    .b_i     (b8),
    .cin_i   (cin8),
`ifdef SERIAL_ADDER_SUB_EN
    .sub_i   (sub8),
`endif
    .busy_o  (busy8),
    .done_o  (done8),
    .sum_o   (sum8),
    .cout_o  (cout8),
    .ovf_o   (ovf8)
  );

  serial_adder #(.WIDTH(16), .BITS_PER_CYCLE(4)) u_dut16 (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start16),
    .a_i     (a16),
    .b_i     (b16),
    .cin_i   (cin16),
`ifdef SERIAL_ADDER_SUB_EN
    .sub_i   (sub16),
`endif
    .busy_o  (busy16),
    .done_o  (done16),
    .sum_o   (sum16),
    .cout_o  (cout16),
    .ovf_o   (ovf16)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitors: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done8) begin
      checks++;
      if (q8.size() == 0) begin
        errors++;
        $display("FAIL done8_unexpected: got %0h expected none", {sum8, cout8, ovf8});
      end else begin
        logic [9:0] e8;
        e8 = q8.pop_front();
        if ({sum8, cout8, ovf8} !== e8) begin
          errors++;
          $display("FAIL result8: got %0h expected %0h", {sum8, cout8, ovf8}, e8);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (done16) begin
      checks++;
      if (q16.size() == 0) begin
        errors++;
        $display("FAIL done16_unexpected: got %0h expected none", {sum16, cout16, ovf16});
      end else begin
        logic [17:0] e16;
        e16 = q16.pop_front();
        if ({sum16, cout16, ovf16} !== e16) begin
          errors++;
          $display("FAIL result16: got %0h expected %0h", {sum16, cout16, ovf16}, e16);
        end
      end
    end
  end

  // One 8-bit operation; glitch>0 re-pulses start with new operands at that busy cycle.
  // Returns at the negedge where done should be high.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s,
                     input logic [7:0] es, input logic ec, input logic eo, input int glitch);
    int n;
    a8 = a; b8 = b; cin8 = c; sub8 = s; start8 = 1'b1;
    q8.push_back({es, ec, eo});
    @(negedge clk);
    start8 = 1'b0;
    chk("busy8_after_start", {31'd0, busy8}, 32'd1);
    n = 1;
    while (n < 40) begin
      if (glitch != 0 && n == glitch) begin
        start8 = 1'b1; a8 = 8'h11; b8 = ~b; cin8 = ~c;
      end else begin
        start8 = 1'b0; a8 = ~a;
      end
      @(negedge clk);
      if (!busy8) break;
      n++;
    end
    start8 = 1'b0;
    chk("busy8_cycles", n, 32'd8);
    chk("done8_latency", {31'd0, done8}, 32'd1);
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic c,
                      input logic [15:0] es, input logic ec, input logic eo);
    int n;
    a16 = a; b16 = b; cin16 = c; start16 = 1'b1;
    q16.push_back({es, ec, eo});
    @(negedge clk);
    start16 = 1'b0;
    chk("busy16_after_start", {31'd0, busy16}, 32'd1);
    n = 1;
    while (n < 40) begin
      b16 = ~b;
      @(negedge clk);
      if (!busy16) break;
      n++;
    end
    chk("busy16_cycles", n, 32'd4);
    chk("done16_latency", {31'd0, done16}, 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy8", {31'd0, busy8}, 32'd0);
    chk("rst_done8", {31'd0, done8}, 32'd0);
    chk("rst_res8", {22'd0, sum8, cout8, ovf8}, 32'd0);
    chk("rst_res16", {14'd0, sum16, cout16, ovf16}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic adds, then back-to-back starts from DONE
    op8(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 0);
    op8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0);
    op8(8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 0);
    op8(8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1, 0);
    repeat (2) @(negedge clk);
    chk("hold_after_done", {22'd0, sum8, cout8, ovf8}, {22'd0, 8'h01, 1'b1, 1'b1});

    // Start pulse and operand changes mid-operation are ignored
    op8(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 4);
    repeat (2) @(negedge clk);

    // Reset at beat 4 aborts the operation with no done
    a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy8_mid", {31'd0, busy8}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy8", {31'd0, busy8}, 32'd0);
    chk("abort_done8", {31'd0, done8}, 32'd0);
    chk("abort_res8", {22'd0, sum8, cout8, ovf8}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("no_done_after_abort", {31'd0, done8}, 32'd0);
    op8(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 0);
    repeat (2) @(negedge clk);

    // 16-bit, 4 bits per clock, back-to-back
    op16(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    op16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    op16(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

`ifdef SERIAL_ADDER_SUB_EN
    op8(8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0, 0);
    op8(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 0);
    op8(8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, 0);
    repeat (2) @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    chk("q8_drained", q8.size(), 32'd0);
    chk("q16_drained", q16.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
